// File: rtl/rom_ctrl_pkg.sv
// ROM controller shared types.
// Sparse sweep FSM encodings, minimum Hamming distance 3.
package rom_ctrl_pkg;

  typedef enum logic [4:0] {
    StIdle     = 5'b00101,
    StReadKmac = 5'b11000,
    StReadTop  = 5'b01110,
    StDone     = 5'b10011
  } state_e;

  function automatic logic state_ok(
    input logic [4:0] s
  );
    return (s == StIdle) || (s == StReadKmac) ||
           (s == StReadTop) || (s == StDone);
  endfunction

endpackage

// File: rtl/prim_count.sv
// Hardened up-counter: a primary count plus an inverted shadow.
// Any disagreement between the two is reported on err_o.
module prim_count #(
  parameter int unsigned Width = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             incr_en_i,
  output logic [Width-1:0] cnt_o,
  output logic             err_o
);

  logic [Width-1:0] cnt_q, cnt_d;
  logic [Width-1:0] inv_q, inv_d;

  assign cnt_d = cnt_q + Width'(1);
  assign inv_d = inv_q - Width'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      inv_q <= '1;
    end else if (incr_en_i) begin
      cnt_q <= cnt_d;
      inv_q <= inv_d;
    end
  end

  assign cnt_o = cnt_q;
  assign err_o = (cnt_q != ~inv_q);

endmodule

// File: rtl/rom_ctrl_sweep.sv
// ROM sweep: streams data-region words to KMAC, then
// captures the top words as the expected digest.
module rom_ctrl_sweep
  import rom_ctrl_pkg::*;
#(
  parameter  int unsigned RomDepth    = 16,
  parameter  int unsigned DigestWords = 8,
  localparam int unsigned AW          = $clog2(RomDepth)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  output logic                      rom_req_o,
  output logic [AW-1:0]             rom_addr_o,
  input  logic [31:0]               rom_rdata_i,
  output logic                      kmac_valid_o,
  output logic [31:0]               kmac_data_o,
  output logic                      kmac_last_o,
  input  logic                      kmac_ready_i,
  output logic [DigestWords*32-1:0] exp_digest_o,
  output logic                      done_o,
  output logic                      cmp_start_o,
  output logic                      alert_o
);

  localparam int unsigned CW = AW + 1;
  localparam int unsigned DataWords = RomDepth - DigestWords;
  localparam logic [CW-1:0] LastData = CW'(DataWords - 1);
  localparam logic [CW-1:0] TopBase  = CW'(DataWords);
  localparam logic [CW-1:0] EndAddr  = CW'(RomDepth);
  localparam logic [CW-1:0] LastTop  = CW'(RomDepth - 1);

  logic [4:0]    state_q, state_d;
  logic [CW-1:0] addr_q;
  logic [CW-1:0] rd_addr;
  logic          cnt_err;
  logic          inflight_q;
  logic          buf_valid_q;
  logic          buf_last_q;
  logic [31:0]   buf_data_q;
  logic          cmp_start_q;
  logic [DigestWords*32-1:0] digest_q;

  logic st_ok, in_read, buf_free, req;
  logic kmac_hs, cap_kmac, cap_top, last_cap;

  assign st_ok   = state_ok(state_q);
  assign in_read = (state_q == StReadKmac) ||
                   (state_q == StReadTop);

  // A draining buffer counts as free so words flow every 2 cycles.
  assign buf_free = !buf_valid_q || kmac_ready_i;
  assign req = in_read && !inflight_q && buf_free &&
               (addr_q < EndAddr);

  assign kmac_hs  = kmac_valid_o && kmac_ready_i;
  assign rd_addr  = addr_q - CW'(1);
  assign cap_kmac = inflight_q && (state_q == StReadKmac);
  assign cap_top  = inflight_q && (state_q == StReadTop);
  assign last_cap = cap_top && (rd_addr == LastTop);

  prim_count #(
    .Width(CW)
  ) u_addr_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .incr_en_i(req),
    .cnt_o    (addr_q),
    .err_o    (cnt_err)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (start_i) state_d = StReadKmac;
      StReadKmac: if (kmac_hs && buf_last_q) state_d = StReadTop;
      StReadTop:  if (last_cap) state_d = StDone;
      StDone:     state_d = StDone;
      default:    state_d = state_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      inflight_q  <= 1'b0;
      cmp_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      inflight_q  <= req;
      cmp_start_q <= (state_q == StReadTop) && last_cap;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_valid_q <= 1'b0;
      buf_last_q  <= 1'b0;
      buf_data_q  <= '0;
    end else if (cap_kmac) begin
      buf_valid_q <= 1'b1;
      buf_last_q  <= (rd_addr == LastData);
      buf_data_q  <= rom_rdata_i;
    end else if (kmac_hs) begin
      buf_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      digest_q <= '0;
    end else if (cap_top) begin
      for (int i = 0; i < DigestWords; i++) begin
        if (rd_addr == TopBase + CW'(i)) begin
          digest_q[i*32 +: 32] <= rom_rdata_i;
        end
      end
    end
  end

  assign rom_req_o    = req;
  assign rom_addr_o   = addr_q[AW-1:0];
  assign kmac_valid_o = buf_valid_q && st_ok;
  assign kmac_data_o  = buf_data_q;
  assign kmac_last_o  = buf_last_q;
  assign exp_digest_o = digest_q;
  assign done_o       = (state_q == StDone);
  assign cmp_start_o  = cmp_start_q && st_ok;

  assign alert_o = !st_ok ||
                   (start_i && (state_q != StIdle)) ||
                   cnt_err ||
                   ((state_q == StIdle) && (addr_q != '0)) ||
                   ((state_q == StDone) && (addr_q != EndAddr));

endmodule

// File: tb/tb_rom_ctrl_sweep.sv
// Directed bench for rom_ctrl_sweep with a KMAC scoreboard
// and a behavioural ROM of A500_0000+i words.
module tb_rom_ctrl_sweep;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         start_i;
  logic         rom_req_o;
  logic [3:0]   rom_addr_o;
  logic [31:0]  rom_rdata_i;
  logic         kmac_valid_o;
  logic [31:0]  kmac_data_o;
  logic         kmac_last_o;
  logic         kmac_ready_i;
  logic [255:0] exp_digest_o;
  logic         done_o;
  logic         cmp_start_o;
  logic         alert_o;

  typedef struct packed {
    logic [31:0] d;
    logic        last;
  } beat_t;

  beat_t        exp_q[$];
  int           n_chk = 0;
  int           n_fail = 0;
  logic [255:0] exp_dig;

  always #5 clk = ~clk;

  rom_ctrl_sweep dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .rom_req_o   (rom_req_o),
    .rom_addr_o  (rom_addr_o),
    .rom_rdata_i (rom_rdata_i),
    .kmac_valid_o(kmac_valid_o),
    .kmac_data_o (kmac_data_o),
    .kmac_last_o (kmac_last_o),
    .kmac_ready_i(kmac_ready_i),
    .exp_digest_o(exp_digest_o),
    .done_o      (done_o),
    .cmp_start_o (cmp_start_o),
    .alert_o     (alert_o)
  );

  always @(posedge clk) begin
    rom_rdata_i <= rom_req_o ?
      (32'hA500_0000 + {28'd0, rom_addr_o}) : 32'hDEAD_BEEF;
  end

  task automatic chk(
    input string        tag,
    input logic [255:0] obs,
    input logic [255:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push8();
    beat_t b;
    for (int i = 0; i < 8; i++) begin
      b.d    = 32'hA500_0000 + i;
      b.last = (i == 7);
      exp_q.push_back(b);
    end
  endtask

  task automatic pop_check();
    beat_t b;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL sb_extra: observed beat %0h expected none",
             kmac_data_o);
    end else begin
      b = exp_q.pop_front();
      chk("kmac_data", kmac_data_o, b.d);
      chk("kmac_last", kmac_last_o, b.last);
    end
  endtask

  task automatic chk_idle();
    chk("idle_req", rom_req_o, 0);
    chk("idle_addr", rom_addr_o, 0);
    chk("idle_valid", kmac_valid_o, 0);
    chk("idle_data", kmac_data_o, 0);
    chk("idle_last", kmac_last_o, 0);
    chk("idle_digest", exp_digest_o, 0);
    chk("idle_done", done_o, 0);
    chk("idle_cmp", cmp_start_o, 0);
    chk("idle_alert", alert_o, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_ni = 1'b0;
    start_i = 1'b0;
    kmac_ready_i = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3 rst_ni = 1'b1;
  endtask

  task automatic sweep(
    input int stall_n,
    input int dup_k,
    input int exp_done
  );
    int beats = 0;
    int reqs = 0;
    int pulses = 0;
    int alerts = 0;
    int done_k = -1;
    int stall_left = stall_n;
    logic [255:0] dig_at_done = '0;
    push8();
    for (int k = 0; k < 120; k++) begin
      @(posedge clk);
      #1;
      start_i = (k == 0) || (k == dup_k);
      kmac_ready_i = 1'b1;
      if (stall_left > 0 && kmac_valid_o &&
          kmac_data_o == 32'hA500_0003) begin
        kmac_ready_i = 1'b0;
        stall_left--;
      end
      #1;
      if (!kmac_ready_i) begin
        chk("stall_data", kmac_data_o, 32'hA500_0003);
        chk("stall_noreq", rom_req_o, 0);
      end
      if (rom_req_o) reqs++;
      if (alert_o) begin
        alerts++;
        chk("alert_cycle", k, dup_k);
      end
      if (cmp_start_o) begin
        pulses++;
        chk("cmp_cycle", k, exp_done);
      end
      if (done_o && done_k < 0) begin
        done_k = k;
        dig_at_done = exp_digest_o;
      end
      if (kmac_valid_o && kmac_ready_i) begin
        pop_check();
        beats++;
      end
      if (done_k >= 0 && k >= done_k + 3) break;
    end
    start_i = 1'b0;
    chk("done_cycle", done_k, exp_done);
    chk("beats", beats, 8);
    chk("reqs", reqs, 16);
    chk("cmp_pulses", pulses, 1);
    chk("alert_count", alerts, (dup_k >= 0) ? 1 : 0);
    chk("digest_done", dig_at_done, exp_dig);
    chk("digest_hold", exp_digest_o, exp_dig);
    chk("done_level", done_o, 1);
    chk("sb_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic abort_at(input int ak);
    push8();
    for (int k = 0; k <= ak; k++) begin
      @(posedge clk);
      #1;
      start_i = (k == 0);
      kmac_ready_i = 1'b1;
      #1;
      if (kmac_valid_o && kmac_ready_i) pop_check();
    end
    #1 rst_ni = 1'b0;
    start_i = 1'b0;
    #1;
    chk_idle();
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #3 rst_ni = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      exp_dig[i*32 +: 32] = 32'hA500_0008 + i;
    end
    rst_ni = 1'b0;
    start_i = 1'b1;
    kmac_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_idle();
    start_i = 1'b0;
    #2 rst_ni = 1'b1;

    sweep(0, -1, 33);
    do_reset();
    sweep(5, -1, 38);
    do_reset();
    sweep(0, 6, 33);
    do_reset();
    abort_at(14);
    sweep(0, -1, 33);
    do_reset();
    abort_at(24);
    sweep(0, -1, 33);
    do_reset();

    @(posedge clk);
    #1 start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (2) @(posedge clk);
    #3 force dut.state_q = 5'b00000;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("fault_alert", alert_o, 1);
      chk("fault_req", rom_req_o, 0);
      chk("fault_valid", kmac_valid_o, 0);
      chk("fault_cmp", cmp_start_o, 0);
    end
    release dut.state_q;
    do_reset();
    #1;
    chk_idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
